// File: rtl/rx_pkg.sv
// ----------------------------------------------------------------------------
// rx_pkg
// Shared definitions for the UART receiver (and the CONTROL/STATUS bit
// positions the transmitter shares with it).
//   rx_state_t  : receiver FSM states
//   ST_*        : STATUS register bit positions
//   CT_*        : CONTROL register bit positions
//   rx_flags_t  : sticky receive flags
//   pack_status : assembles the 8-bit STATUS register
// ----------------------------------------------------------------------------
package rx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    localparam int unsigned ST_VALID = 0;
    localparam int unsigned ST_FERR  = 1;
    localparam int unsigned ST_OVR   = 2;
    localparam int unsigned ST_BUSY  = 3;

    localparam int unsigned CT_EN    = 0;
    localparam int unsigned CT_ACK   = 1;

    typedef struct packed {
        logic ovr;
        logic ferr;
        logic valid;
    } rx_flags_t;

    function automatic logic [7:0] pack_status(input rx_flags_t flags,
                                               input logic      busy);
        logic [7:0] s;
        s           = '0;
        s[ST_VALID] = flags.valid;
        s[ST_FERR]  = flags.ferr;
        s[ST_OVR]   = flags.ovr;
        s[ST_BUSY]  = busy;
        return s;
    endfunction

endpackage

// File: rtl/rx_line_sync.sv
// ----------------------------------------------------------------------------
// rx_line_sync
// Two-flop synchroniser for the asynchronous serial line, followed by a
// history flop used for falling-edge detection. All flops reset to 1 so an
// idle (high) line never produces a spurious edge out of reset.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   line_in : raw asynchronous serial input
//   rx      : synchronised line level
//   fall    : high for one cycle when rx goes 1 -> 0
// ----------------------------------------------------------------------------
module rx_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic rx,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= line_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rx   = sync;
    // Decoded purely from flops, so it is glitch-free.
    assign fall = prev & ~sync;

endmodule

// File: rtl/rx_block.sv
// ----------------------------------------------------------------------------
// rx_block
// UART receiver, 8N1, idle high, LSB first. Deserialises frames from LINE_IN
// and presents the byte through DATA/STATUS registers.
//   CLKS_PER_BIT : system clocks per serial bit (even, >= 4)
//   CLK          : system clock, rising edge
//   RST          : asynchronous active-high reset
//   CONTROL      : bit0 EN (receiver enable), bit1 ACK (clear flags, level)
//   LINE_IN      : asynchronous serial input
//   DATA         : last correctly received byte
//   STATUS       : bit0 VALID, bit1 FERR, bit2 OVR, bit3 BUSY, bits 7:4 zero
// ----------------------------------------------------------------------------
module rx_block
    import rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] CONTROL,
    input  logic       LINE_IN,
    output logic [7:0] DATA,
    output logic [7:0] STATUS
);

    localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
    localparam logic [TICK_W-1:0] HALF_M1 = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_M1 = TICK_W'(CLKS_PER_BIT - 1);

    logic rx;
    logic fall;
    logic en;
    logic ack;
    logic ctrl_unused;

    rx_state_t         state,   state_n;
    logic [TICK_W-1:0] tick,    tick_n;
    logic [2:0]        idx,     idx_n;
    logic [7:0]        shift,   shift_n;
    logic [7:0]        data_q,  data_n;
    rx_flags_t         flags,   flags_n;

    assign en          = CONTROL[CT_EN];
    assign ack         = CONTROL[CT_ACK];
    assign ctrl_unused = ^CONTROL[7:2];

    rx_line_sync u_sync (
        .clk     (CLK),
        .rst     (RST),
        .line_in (LINE_IN),
        .rx      (rx),
        .fall    (fall)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            tick   <= '0;
            idx    <= '0;
            shift  <= '0;
            data_q <= '0;
            flags  <= '0;
        end else begin
            state  <= state_n;
            tick   <= tick_n;
            idx    <= idx_n;
            shift  <= shift_n;
            data_q <= data_n;
            flags  <= flags_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick + TICK_W'(1);
        idx_n   = idx;
        shift_n = shift;
        data_n  = data_q;
        // ACK is applied before any stop-bit completion in the same cycle,
        // so completion below sees the already-cleared flags.
        flags_n = ack ? rx_flags_t'('0) : flags;

        unique case (state)
            S_IDLE: begin
                tick_n = '0;
                if (fall && en) begin
                    state_n = S_START;
                end
            end

            S_START: begin
                if (tick == HALF_M1) begin
                    tick_n = '0;
                    idx_n  = '0;
                    // A line already back high mid-start-bit was a glitch.
                    state_n = rx ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (tick == FULL_M1) begin
                    tick_n  = '0;
                    shift_n = {rx, shift[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (tick == FULL_M1) begin
                    tick_n  = '0;
                    // Leaving at mid stop bit leaves room for a back-to-back
                    // start edge.
                    state_n = S_IDLE;
                    if (!rx) begin
                        flags_n.ferr = 1'b1;
                    end else if (flags_n.valid) begin
                        flags_n.ovr = 1'b1;
                    end else begin
                        data_n        = shift;
                        flags_n.valid = 1'b1;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
                tick_n  = '0;
            end
        endcase

        if (!en) begin
            state_n = S_IDLE;
            tick_n  = '0;
        end
    end

    assign DATA   = data_q;
    assign STATUS = pack_status(flags, state != S_IDLE);

endmodule

// File: tb/tb_rx_block.sv
`timescale 1ns/1ps
module tb_rx_block;
    import rx_pkg::*;

    localparam int unsigned C = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] control = 8'h00;
    logic       line = 1'b1;
    logic [7:0] data;
    logic [7:0] status;

    int n_cmp = 0;
    int n_err = 0;

    rx_block #(.CLKS_PER_BIT(C)) dut (
        .CLK     (clk),
        .RST     (rst),
        .CONTROL (control),
        .LINE_IN (line),
        .DATA    (data),
        .STATUS  (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       ack_hold;
        logic [7:0] exp_data;
        logic [7:0] exp_status;
        logic       ack_after;
        logic [7:0] exp_after;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
        end
    endtask

    // Clock-aligned frame: each bit lasts exactly C cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            line = bits[i];
            repeat (C) @(posedge clk);
            #1;
        end
        line = 1'b1;
    endtask

    // Free-running frame with an arbitrary bit period in ns.
    task automatic send_frame_ns(input logic [7:0] d, input int bit_ns);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            line = bits[i];
            #(bit_ns);
        end
        line = 1'b1;
    endtask

    task automatic ack_pulse;
        @(posedge clk); #1;
        control[CT_ACK] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        control[CT_ACK] = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev_data;

        vecs[0] = '{8'h4E, 1'b1, 1'b0, 8'h4E, 8'h01, 1'b1, 8'h00};
        vecs[1] = '{8'hA5, 1'b0, 1'b0, 8'h4E, 8'h02, 1'b1, 8'h00};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 8'h01, 1'b0, 8'h00};
        vecs[3] = '{8'h22, 1'b1, 1'b0, 8'h11, 8'h05, 1'b1, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00};
        vecs[5] = '{8'h33, 1'b1, 1'b1, 8'h33, 8'h01, 1'b1, 8'h00};
        vecs[6] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 8'h01, 1'b1, 8'h00};
        vecs[7] = '{8'h80, 1'b0, 1'b0, 8'h5A, 8'h02, 1'b1, 8'h00};

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset data", data, 8'h00);
        chk("reset status", status, 8'h00);
        #1 rst = 1'b0;
        control[CT_EN] = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("post-reset status", status, 8'h00);

        // Table-driven frames: results visible exactly at t+153 (after edge 155).
        prev_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            fork
                send_frame(vecs[i].d, vecs[i].stop);
                begin
                    repeat (150) @(posedge clk);
                    #1;
                    if (vecs[i].ack_hold) control[CT_ACK] = 1'b1;
                    repeat (4) @(posedge clk);
                    @(negedge clk);
                    chk($sformatf("vec%0d busy@t+152", i), {7'd0, status[ST_BUSY]}, 8'h01);
                    chk($sformatf("vec%0d data@t+152", i), data, prev_data);
                    @(posedge clk); #1;
                    control[CT_ACK] = 1'b0;
                    @(negedge clk);
                    chk($sformatf("vec%0d data", i), data, vecs[i].exp_data);
                    chk($sformatf("vec%0d status", i), status, vecs[i].exp_status);
                end
            join
            if (vecs[i].ack_after) begin
                ack_pulse();
                chk($sformatf("vec%0d status after ack", i), status, vecs[i].exp_after);
                chk($sformatf("vec%0d data after ack", i), data, vecs[i].exp_data);
            end
            prev_data = vecs[i].exp_data;
            repeat (4) @(posedge clk);
        end

        // Glitch: 3-cycle low pulse
        @(posedge clk); #1;
        fork
            begin
                line = 1'b0;
                repeat (3) @(posedge clk);
                #1 line = 1'b1;
            end
            begin
                for (int e = 1; e <= 11; e++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (e == 2)  chk("glitch busy@t", status, 8'h00);
                    if (e == 3)  chk("glitch busy@t+1", status, 8'h08);
                    if (e == 10) chk("glitch busy@t+8", status, 8'h08);
                    if (e == 11) chk("glitch status@t+9", status, 8'h00);
                end
            end
        join
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("glitch data", data, 8'h5A);

        // Baud tolerance: -3% and +3% bit period (nominal 160 ns)
        @(posedge clk); #1;
        send_frame_ns(8'hC3, 155);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("fast data", data, 8'hC3);
        chk("fast status", status, 8'h01);
        ack_pulse();
        @(posedge clk); #3;
        send_frame_ns(8'h69, 165);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("slow data", data, 8'h69);
        chk("slow status", status, 8'h01);
        ack_pulse();
        repeat (4) @(posedge clk);

        // Drop EN mid-frame
        @(posedge clk); #1;
        fork
            send_frame(8'h3C, 1'b1);
            begin
                repeat (59) @(posedge clk);
                @(negedge clk);
                chk("en busy before drop", status, 8'h08);
                @(posedge clk); #1;
                control[CT_EN] = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("en drop status", status, 8'h00);
            end
        join
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("en drop final status", status, 8'h00);
        chk("en drop data", data, 8'h69);
        control[CT_EN] = 1'b1;
        repeat (4) @(posedge clk);

        // Reset during data bit 4 of a frame
        @(posedge clk); #1;
        fork
            send_frame(8'hF5, 1'b1);
            begin
                repeat (88) @(posedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                chk("midreset data", data, 8'h00);
                chk("midreset status", status, 8'h00);
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("after midreset data", data, 8'h00);
        chk("after midreset status", status, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx_block.md
# rx_block

UART receiver for the RISCV_CPU peripheral set, and the counterpart of the existing transmitter block. It samples a single asynchronous serial line carrying 8N1 frames (idle high, LSB first) and deserialises each frame into a byte. It presents the byte on an 8-bit DATA register alongside 8-bit CONTROL and STATUS registers, using the same register-level handshake style as the transmitter. It sits beside the transmitter on the CPU's peripheral bus; its line input is driven by an external pin, or by the transmitter's line output for loopback.

## Interface
- CLKS_PER_BIT, default 16: system clock cycles per serial bit. Must be even and ≥ 4.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CONTROL  in  8  bit0 EN (receiver enable); bit1 ACK (clear flags); bits 7:2 ignored.
- LINE_IN  in  1  asynchronous serial input; idles high.
- DATA  out  8  last correctly received byte.
- STATUS  out  8  bit0 VALID; bit1 FERR (framing error); bit2 OVR (overrun); bit3 BUSY (FSM not IDLE); bits 7:4 always 0.

## Operation
- LINE_IN passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised signal (rx).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on an rx falling edge (previous rx 1, current rx 0) with EN=1 -> START; tick counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then sample rx. If rx=0 -> DATA, with bit index 0 and tick counter cleared. If rx=1 the start was a glitch -> IDLE, with no flag change.
  - DATA: sample rx every CLKS_PER_BIT cycles into a shift register, LSB first. After bit index 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx, then -> IDLE.
    - rx=1 and VALID=0: DATA <= shift register; set VALID.
    - rx=1 and VALID=1 (without a same-cycle ACK): set OVR. The new byte is discarded and DATA keeps the old byte.
    - rx=0: set FERR. DATA is not updated.
- Returning to IDLE at the middle of the stop bit allows back-to-back frames.
- ACK is level-sensitive. In every cycle that CONTROL[1]=1, VALID, FERR and OVR are cleared.
- ACK and stop-bit completion in the same cycle: ACK applies first, then completion. The result is VALID=1, OVR=0, and DATA holds the new byte.
- EN=0: the FSM is forced to IDLE and any partial frame is abandoned. DATA and the flags hold their values, and ACK still works.
- Reset (RST=1, at any time, including mid-frame): DATA=0x00, STATUS=0x00, FSM=IDLE, counters=0, synchroniser flops=1. No partial frame survives reset.

## Timing
- Let t be the cycle in which the synchronised falling edge is detected. This is 2 cycles after the raw LINE_IN edge.
- Start-bit check at t+CLKS_PER_BIT/2.
- Data bit i (i = 0..7) is sampled at t+CLKS_PER_BIT/2+CLKS_PER_BIT·(i+1).
- Stop bit is sampled at t+CLKS_PER_BIT/2+9·CLKS_PER_BIT. With the default CLKS_PER_BIT=16 this is t+152.
- VALID/FERR/OVR and DATA become visible on the next rising edge. With the default this is t+153.
- The flag clear is visible the cycle after ACK is sampled high.
- BUSY=1 from t+1 until the cycle after the stop sample.
- Tolerance: a baud mismatch of up to ±3% between transmitter and receiver must be received correctly.

## Structure
- Shared package rx_pkg holds:
  - FSM state enum: IDLE, START, DATA, STOP.
  - STATUS bit indices: ST_VALID=0, ST_FERR=1, ST_OVR=2, ST_BUSY=3.
  - CONTROL bit indices: CT_EN=0, CT_ACK=1.
  - The transmitter reuses the CONTROL/STATUS index constants where they apply.
- One sub-module, rx_line_sync: the 2-flop synchroniser plus a registered falling-edge detect, with an asynchronous reset to 1.
- Tick counter width is $clog2(CLKS_PER_BIT); bit index is 3 bits.

## Test plan
- Clean frame: RST pulse, EN=1, drive 0x4E (78) at CLKS_PER_BIT=16 -> at t+153 DATA=0x4E and STATUS=0x01. Then ACK for one cycle -> STATUS=0x00 and DATA stays 0x4E.
- Loopback: connect the transmitter's line output to LINE_IN and send DATA=78 through the transmitter handshake -> the receiver reports DATA=0x4E and VALID with FERR=OVR=0.
- Glitch and framing error:
  - A 3-cycle low pulse on LINE_IN -> no flag change, and BUSY returns to 0 by t+9.
  - A frame for 0xA5 with the stop bit driven 0 -> STATUS=0x02 and DATA unchanged.
- Overrun: receive 0x11 without ACK, then receive 0x22 -> STATUS=0x05 and DATA=0x11. ACK -> STATUS=0x00.
- Simultaneous ACK/completion: VALID=1 with ACK held high through the stop sample of 0x33 -> DATA=0x33 and STATUS=0x01 (OVR=0).
- Reset and disable mid-frame:
  - Assert RST at bit 4 of a frame -> next cycle DATA=0x00 and STATUS=0x00. The remainder of that frame is not reported as a byte. If its remaining low bits produce a falling edge, only a FERR is allowed.
  - Drop EN mid-frame -> BUSY=0 the next cycle and no flags set.
